issue_select_rr: RTL and testbench

ISSUE_SELECT_RR -- requirements
Module: issue_select_rr

---
 rtl/issue_select_rr_pkg.sv | 21 ++
 rtl/issue_select_rr_pick_first.sv | 37 +++
 rtl/issue_select_rr.sv | 119 +++++++++++
 tb/tb_issue_select_rr.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/issue_select_rr_pkg.sv
// ============================================================================
// Module  : issue_select_rr_pkg
// Brief   : Shared mode enumeration and parameter defaults for issue_select_rr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package issue_select_rr_pkg;

  typedef enum logic {
    SEL_RR  = 1'b0,
    SEL_ROT = 1'b1
  } sel_mode_e;

  localparam int DEF_N_REQ        = 8;
  localparam int DEF_N_GNT        = 2;
  localparam int DEF_STARVE_LIMIT = 4;

endpackage

`default_nettype wire

// File: rtl/issue_select_rr_pick_first.sv
// ============================================================================
// Module  : rr_pick_first
// Brief   : First set bit of a mask, searching upward from a start index with wrap.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick_first #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_mask,
  input  logic [W-1:0] i_start,
  output logic         o_found,
  output logic [W-1:0] o_idx,
  output logic [N-1:0] o_onehot
);

  logic [N-1:0] w_rot;
  logic [W-1:0] w_off;

  // Rotating by the start index turns the wrapped search into a lowest-bit search;
  // the W-bit add back wraps for free because N is a power of two.
  always_comb begin
    w_rot   = N'({i_mask, i_mask} >> i_start);
    w_off   = '0;
    o_found = |i_mask;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = W'(j);
    end
    o_idx    = o_found ? (i_start + w_off) : '0;
    o_onehot = o_found ? (N'(1) << o_idx) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/issue_select_rr.sv
// ============================================================================
// Module  : issue_select_rr
// Brief   : Multi-slot round-robin issue select with starvation-age override.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_select_rr
  import issue_select_rr_pkg::*;
#(
  parameter int N_REQ        = DEF_N_REQ,
  parameter int N_GNT        = DEF_N_GNT,
  parameter int MODE         = int'(SEL_RR),
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                                  i_clock,
  input  logic                                  i_reset,
  input  logic                                  i_en,
  input  logic [N_REQ-1:0]                      i_req,
  output logic [N_GNT-1:0][N_REQ-1:0]           o_gnt,
  output logic [N_GNT-1:0]                      o_gnt_valid,
  output logic [N_GNT-1:0][$clog2(N_REQ)-1:0]   o_gnt_idx,
  output logic [N_REQ-1:0]                      o_gnt_any
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  logic [IDX_W-1:0]            r_ptr;
  logic [N_REQ-1:0][AGE_W-1:0] r_age;

  logic             w_active;
  logic [N_REQ-1:0] w_starved;
  logic [N_REQ-1:0] w_mask   [N_GNT];
  logic [N_REQ-1:0] w_oh     [N_GNT];
  logic [N_REQ-1:0] w_taken  [N_GNT+1];
  logic             w_found  [N_GNT];
  logic [IDX_W-1:0] w_idx    [N_GNT];
  logic [N_REQ-1:0] w_any_rot;
  logic [IDX_W-1:0] w_last_off;
  logic [IDX_W-1:0] w_ptr_nxt;

  assign w_active   = i_en && !i_reset;
  assign w_taken[0] = '0;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_starved[i] = i_req[i] && (r_age[i] == AGE_W'(STARVE_LIMIT));
    end
  end

  generate
    for (genvar k = 0; k < N_GNT; k++) begin : g_slot
      if (k == 0) begin : g_first
        assign w_mask[k] = (|w_starved) ? w_starved : i_req;
      end else begin : g_rest
        assign w_mask[k] = i_req & ~w_taken[k];
      end

      rr_pick_first #(
        .N (N_REQ),
        .W (IDX_W)
      ) u_pick (
        .i_mask   (w_mask[k]),
        .i_start  (r_ptr),
        .o_found  (w_found[k]),
        .o_idx    (w_idx[k]),
        .o_onehot (w_oh[k])
      );

      assign w_taken[k+1]   = w_taken[k] | w_oh[k];
      assign o_gnt[k]       = w_active ? w_oh[k] : '0;
      assign o_gnt_valid[k] = w_active && w_found[k];
      assign o_gnt_idx[k]   = o_gnt_valid[k] ? w_idx[k] : '0;
    end
  endgenerate

  always_comb begin
    o_gnt_any = '0;
    for (int k = 0; k < N_GNT; k++) begin
      o_gnt_any = o_gnt_any | o_gnt[k];
    end
  end

  // The last grant in priority order is the highest set bit once rotated by ptr.
  always_comb begin
    w_any_rot  = N_REQ'({o_gnt_any, o_gnt_any} >> r_ptr);
    w_last_off = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (w_any_rot[j]) w_last_off = IDX_W'(j);
    end
    if (MODE == int'(SEL_ROT)) begin
      w_ptr_nxt = r_ptr + IDX_W'(1);
    end else if (|o_gnt_any) begin
      w_ptr_nxt = r_ptr + w_last_off + IDX_W'(1);
    end else begin
      w_ptr_nxt = r_ptr;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ptr <= '0;
      r_age <= '0;
    end else if (i_en) begin
      r_ptr <= w_ptr_nxt;
      for (int i = 0; i < N_REQ; i++) begin
        if (o_gnt_any[i] || !i_req[i]) begin
          r_age[i] <= '0;
        end else if (r_age[i] != AGE_W'(STARVE_LIMIT)) begin
          r_age[i] <= r_age[i] + AGE_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_issue_select_rr.sv
// ============================================================================
// Module  : tb_issue_select_rr
// Brief   : Directed and randomized bench for two issue_select_rr configurations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_issue_select_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       en0 = 1'b0;
  logic       en1 = 1'b0;
  logic [7:0] rq0 = '0;
  logic [7:0] rq1 = '0;

  logic [1:0][7:0] g0;
  logic [1:0]      v0;
  logic [1:0][2:0] x0;
  logic [7:0]      a0;
  logic [0:0][7:0] g1;
  logic [0:0]      v1;
  logic [0:0][2:0] x1;
  logic [7:0]      a1;

  issue_select_rr u_dut0 (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_en        (en0),
    .i_req       (rq0),
    .o_gnt       (g0),
    .o_gnt_valid (v0),
    .o_gnt_idx   (x0),
    .o_gnt_any   (a0)
  );

  issue_select_rr #(
    .N_REQ        (8),
    .N_GNT        (1),
    .MODE         (1),
    .STARVE_LIMIT (3)
  ) u_dut1 (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_en        (en1),
    .i_req       (rq1),
    .o_gnt       (g1),
    .o_gnt_valid (v1),
    .o_gnt_idx   (x1),
    .o_gnt_any   (a1)
  );

  int n_cmp = 0;
  int n_err = 0;
  int m_ptr [2];
  int m_age [2][8];

  function automatic int cfg_ngnt(int u); return (u == 0) ? 2 : 1; endfunction
  function automatic int cfg_lim(int u);  return (u == 0) ? 4 : 3; endfunction
  function automatic int cfg_mode(int u); return (u == 0) ? 0 : 1; endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per slot k: bits [4k+3] valid, [4k+2:4k] index.
  function automatic logic [15:0] model_sel(int u, logic [7:0] rq);
    logic [7:0]  taken;
    logic [15:0] res;
    int s, i, p, lim;
    taken = '0;
    res   = '0;
    p     = m_ptr[u];
    lim   = cfg_lim(u);
    for (int k = 0; k < cfg_ngnt(u); k++) begin
      s = -1;
      if (k == 0) begin
        for (int d = 0; d < 8; d++) begin
          i = (p + d) % 8;
          if (s < 0 && rq[i] && m_age[u][i] == lim) s = i;
        end
      end
      for (int d = 0; d < 8; d++) begin
        i = (p + d) % 8;
        if (s < 0 && rq[i] && !taken[i]) s = i;
      end
      if (s >= 0) begin
        taken[s] = 1'b1;
        res[k*4 +: 4] = {1'b1, 3'(s)};
      end
    end
    return res;
  endfunction

  task automatic model_step(int u, logic r, logic e, logic [7:0] rq, logic [15:0] s);
    logic [7:0] g;
    int far, fd, idx, d;
    g   = '0;
    far = -1;
    fd  = -1;
    for (int k = 0; k < cfg_ngnt(u); k++) begin
      if (s[k*4+3]) begin
        idx    = int'(s[k*4 +: 3]);
        g[idx] = 1'b1;
        d      = (idx - m_ptr[u] + 8) % 8;
        if (d > fd) begin
          fd  = d;
          far = idx;
        end
      end
    end
    if (r) begin
      m_ptr[u] = 0;
      for (int i = 0; i < 8; i++) m_age[u][i] = 0;
    end else if (e) begin
      if (cfg_mode(u) == 1) m_ptr[u] = (m_ptr[u] + 1) % 8;
      else if (far >= 0)    m_ptr[u] = (far + 1) % 8;
      for (int i = 0; i < 8; i++) begin
        if (g[i] || !rq[i])               m_age[u][i] = 0;
        else if (m_age[u][i] < cfg_lim(u)) m_age[u][i] = m_age[u][i] + 1;
      end
    end
  endtask

  task automatic cycle(string tag, logic r, logic e0, logic [7:0] q0,
                       logic e1, logic [7:0] q1,
                       bit cd0, logic [7:0] d0, bit cd1, logic [3:0] d1);
    logic [15:0] s0, s1, eg0;
    logic [7:0]  eg1;
    @(negedge clk);
    rst = r; en0 = e0; rq0 = q0; en1 = e1; rq1 = q1;
    #1;
    s0 = (r || !e0) ? 16'h0 : model_sel(0, q0);
    s1 = (r || !e1) ? 16'h0 : model_sel(1, q1);
    eg0 = '0;
    for (int k = 0; k < 2; k++) begin
      if (s0[k*4+3]) eg0[k*8 +: 8] = 8'd1 << s0[k*4 +: 3];
    end
    eg1 = s1[3] ? (8'd1 << s1[2:0]) : 8'd0;
    check({tag, "_u0_slots"}, 32'({v0[1], x0[1], v0[0], x0[0]}), 32'(s0[7:0]));
    check({tag, "_u0_gnt"},   32'(g0), 32'(eg0));
    check({tag, "_u0_any"},   32'(a0), 32'(eg0[7:0] | eg0[15:8]));
    check({tag, "_u1_slots"}, 32'({v1[0], x1[0]}), 32'(s1[3:0]));
    check({tag, "_u1_gnt"},   32'(g1), 32'(eg1));
    check({tag, "_u1_any"},   32'(a1), 32'(eg1));
    if (cd0) check({tag, "_u0_const"}, 32'({v0[1], x0[1], v0[0], x0[0]}), 32'(d0));
    if (cd1) check({tag, "_u1_const"}, 32'({v1[0], x1[0]}), 32'(d1));
    @(posedge clk);
    model_step(0, r, e0, q0, s0);
    model_step(1, r, e1, q1, s1);
  endtask

  initial begin
    logic       r, e0, e1;
    logic [7:0] q0, q1;
    for (int u = 0; u < 2; u++) begin
      m_ptr[u] = 0;
      for (int i = 0; i < 8; i++) m_age[u][i] = 0;
    end

    cycle("rst",   1'b1, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 4'h0);
    cycle("ff1",   1'b0, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1, 8'h98, 1'b1, 4'h0);
    cycle("ff2",   1'b0, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1, 8'hBA, 1'b1, 4'h0);
    cycle("one5",  1'b0, 1'b1, 8'h20, 1'b1, 8'h03, 1'b1, 8'h0D, 1'b1, 4'h8);
    cycle("wrap",  1'b0, 1'b1, 8'h41, 1'b1, 8'h03, 1'b1, 8'h8E, 1'b1, 4'h8);
    cycle("one4",  1'b0, 1'b1, 8'h10, 1'b1, 8'h03, 1'b1, 8'h0C, 1'b1, 4'h8);
    cycle("off1",  1'b0, 1'b0, 8'hFF, 1'b1, 8'h03, 1'b1, 8'h00, 1'b1, 4'h9);
    cycle("off2",  1'b0, 1'b0, 8'hFF, 1'b1, 8'h03, 1'b1, 8'h00, 1'b0, 4'h0);
    cycle("off3",  1'b0, 1'b0, 8'hFF, 1'b1, 8'h03, 1'b1, 8'h00, 1'b0, 4'h0);
    cycle("hold",  1'b0, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'hED, 1'b0, 4'h0);
    cycle("mrst",  1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1, 4'h0);
    cycle("post",  1'b0, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h98, 1'b1, 4'h8);

    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 59) == 0);
      e0 = ($urandom_range(0, 7) != 0);
      e1 = ($urandom_range(0, 7) != 0);
      q0 = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
      q1 = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom);
      cycle("rnd", r, e0, q0, e1, q1, 1'b0, 8'h00, 1'b0, 4'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
